// File: rtl/sbox_round_sequencer.sv
// Shares one S-box port across 8 DES lookups per word; out_valid 9 cycles after accept (10 with SBOX_REG_EN,
// registered S-box port). out_data is held while out_ready is low, and in_ready stays low until the word drains.
module sbox_round_sequencer #(
  parameter int NUM_BOX = 8,
  parameter int SIN_W   = 6,
  parameter int SOUT_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_BOX*SIN_W-1:0]    in_data,
  output logic [$clog2(NUM_BOX)-1:0]  sbox_sel,
  output logic [SIN_W-1:0]            sbox_addr,
  input  logic [SOUT_W-1:0]           sbox_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_BOX*SOUT_W-1:0]   out_data,
  output logic                        busy
);

  localparam int IN_W  = NUM_BOX * SIN_W;
  localparam int OUT_W = NUM_BOX * SOUT_W;
  localparam int SEL_W = $clog2(NUM_BOX);
  localparam int CNT_W = $clog2(NUM_BOX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ISSUE = CNT_W'(NUM_BOX);
`ifdef SBOX_REG_EN
  // one extra drain cycle collects the last registered result
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BOX);
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BOX - 1);
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  shreg;
  logic [OUT_W-1:0] result;
  logic             in_lookup;
  logic             issue;
  logic             cap_en;
  logic [SEL_W-1:0] cap_idx;

  assign in_lookup = (state == ST_LOOKUP);
  assign issue     = in_lookup && (cnt < CNT_ISSUE);

`ifdef SBOX_REG_EN
  // the result arriving now belongs to the address issued last cycle
  assign cap_en  = in_lookup && (cnt != '0);
  assign cap_idx = SEL_W'(cnt - CNT_W'(1));
`else
  assign cap_en  = in_lookup;
  assign cap_idx = cnt[SEL_W-1:0];
`endif

  assign sbox_sel  = issue ? cnt[SEL_W-1:0] : '0;
  assign sbox_addr = issue ? shreg[IN_W-1 -: SIN_W] : '0;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      result   <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            result   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (cap_en) begin
            for (int i = 0; i < NUM_BOX; i++) begin
              if (cap_idx == SEL_W'(i)) begin
                result[OUT_W-1-SOUT_W*i -: SOUT_W] <= sbox_data;
              end
            end
          end
          shreg <= shreg << SIN_W;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_ready rises together with the return to IDLE, never in DONE itself
          if (out_ready) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_round_sequencer.sv
// Randomized bench for sbox_round_sequencer against a word-level DES S-box reference; honours SBOX_REG_EN.
module tb_sbox_round_sequencer;

`ifdef SBOX_REG_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic [3:0]  sbox_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [31:0] last_out;

  sbox_round_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sbox_sel(sbox_sel), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] des_sbox(input int box, input logic [5:0] a);
    logic [255:0] t;
    int row, col;
    case (box)
      0: t = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
      1: t = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
      2: t = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
      3: t = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
      4: t = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
      5: t = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
      6: t = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
      default: t = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    endcase
    row = int'({a[5], a[0]});
    col = int'(a[4:1]);
    return t[255 - 64*row - 4*col -: 4];
  endfunction

  function automatic logic [31:0] ref_word(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[31-4*i -: 4] = des_sbox(i, d[47-6*i -: 6]);
    return r;
  endfunction

`ifdef SBOX_REG_EN
  always @(posedge clk) sbox_data <= des_sbox(int'(sbox_sel), sbox_addr);
`else
  always_comb sbox_data = des_sbox(int'(sbox_sel), sbox_addr);
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one word and drains it; hold = cycles out_ready stays low once out_valid is up.
  // With stall_in, the next word nd is offered while this one is still in flight.
  task automatic do_word(input logic [47:0] d, input int hold, input bit stall_in,
                         input logic [47:0] nd, input int exp_gap);
    int k;
    logic [31:0] held;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("acc_rdy", 64'(in_ready), 64'(1));
    if (exp_gap > 0) chk("acc_gap", 64'(cyc - last_acc), 64'(exp_gap));
    last_acc = cyc;
    @(negedge clk);
    in_valid = stall_in;
    if (stall_in) in_data = nd;
    chk("busy", 64'(busy), 64'(1));
    chk("rdy_lookup", 64'(in_ready), 64'(0));
    k = 1;
    while (!out_valid && k < 40) begin
      if (k <= 8) begin
        chk("sel", 64'(sbox_sel), 64'(k - 1));
        chk("addr", 64'(sbox_addr), 64'(d[47-6*(k-1) -: 6]));
      end
      @(negedge clk);
      k++;
    end
    chk("lat", 64'(k), 64'(LAT));
    chk("data", 64'(out_data), 64'(ref_word(d)));
    held = out_data;
    last_out = out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_vld", 64'(out_valid), 64'(1));
      chk("bp_dat", 64'(out_data), 64'(held));
      chk("bp_rdy", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_vld", 64'(out_valid), 64'(0));
    chk("hs_rdy", 64'(in_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    logic [47:0] w [0:8];
    int hold [0:8];
    int k;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_vld", 64'(out_valid), 64'(0));
    chk("rst_dat", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sel", 64'(sbox_sel), 64'(0));
    chk("rst_addr", 64'(sbox_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(in_ready), 64'(1));

    // known answers, back to back with out_ready high
    do_word(48'h0, 0, 1'b0, 48'h0, 0);
    chk("kat_zero", 64'(last_out), 64'(32'hEFA72C4D));
    do_word(48'hFFFFFFFFFFFF, 0, 1'b0, 48'h0, LAT + 1);
    chk("kat_ones", 64'(last_out), 64'(32'hD9CE3DCB));

    // backpressure with the next word waiting upstream
    w[0] = {16'($urandom), $urandom};
    w[1] = {16'($urandom), $urandom};
    do_word(w[0], 5, 1'b1, w[1], LAT + 1);
    do_word(w[1], 0, 1'b0, 48'h0, LAT + 1 + 5);

    // reset in the middle of a lookup sequence
    in_data = {16'($urandom), $urandom} | 48'h1;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (sbox_sel != 3'd4 && k < 40) begin @(negedge clk); k++; end
    chk("mid_sel", 64'(sbox_sel), 64'(4));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_vld", 64'(out_valid), 64'(0));
    chk("mid_dat", 64'(out_data), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_rdy", 64'(in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rdy_after", 64'(in_ready), 64'(1));
    do_word(48'h0, 0, 1'b0, 48'h0, 0);
    chk("kat_after_rst", 64'(last_out), 64'(32'hEFA72C4D));

    // randomized traffic
    for (int i = 0; i < 9; i++) begin
      w[i] = {16'($urandom), $urandom};
      hold[i] = int'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      do_word(w[i], hold[i], 1'($urandom_range(0, 1)), w[i+1],
              (i == 0) ? 0 : LAT + 1 + hold[i-1]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
